// File: rtl/mtm_alu_ser_pkg.sv
// Shared types and helpers for the ALU result frame serializer.
// Frame layout (MSB first): start 0, type bit, 8-bit payload, stop 1.
package mtm_alu_ser_pkg;

   typedef enum logic [2:0] {StIdle, StLoad, StShift, StGap, StFin} ser_state_e;

   localparam int unsigned FRAME_BITS = 11;
   localparam logic        TYPE_DATA  = 1'b0;
   localparam logic        TYPE_CTL   = 1'b1;
   localparam logic [2:0]  CRC3_POLY  = 3'b011;

   function automatic logic [7:0] err_payload(input logic [2:0] err);
      logic par;
      par = ^{1'b1, err, err};
      return {1'b1, err, err, par};
   endfunction

   function automatic logic [FRAME_BITS-1:0] make_frame(input logic typ, input logic [7:0] payload);
      return {1'b0, typ, payload, 1'b1};
   endfunction

   // One MSB-first step of the x^3+x+1 CRC.
   function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic b);
      logic fb;
      fb = crc[2] ^ b;
      return {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
   endfunction

endpackage

// File: rtl/mtm_ser_baud_gen.sv
// Bit-period timer: tick is high on the last clock of every CLK_DIV-cycle period.
// clear restarts the period so the first bit after accept gets its full length.
module mtm_ser_baud_gen #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/mtm_alu_frame_serializer.sv
// Serializes one ALU result into 11-bit frames on sout (data frames then control, or one
// error frame). Optional MTM_SER_CRC_GEN_EN: CRC generated internally instead of crc_in.
module mtm_alu_frame_serializer
   import mtm_alu_ser_pkg::*;
#(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned GAP_BITS   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*DATA_BYTES-1:0] data_in,
   input  logic [3:0]              flags_in,
   input  logic [2:0]              crc_in,
   input  logic [2:0]              err_in,
   output logic                    sout,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned FW = $clog2(DATA_BYTES + 2);
   localparam int unsigned DW = 8 * DATA_BYTES;

   ser_state_e state_q, state_d;

   logic [DW-1:0]         data_q;
   logic [3:0]            flags_q;
   logic [2:0]            err_q;
   logic [2:0]            crc_val;
   logic [FRAME_BITS-1:0] shreg_q;
   logic [3:0]            bit_cnt_q;
   logic [FW-1:0]         frame_cnt_q;

   logic                  accept, tick, last_frame;
   logic [7:0]            byte_sel;
   logic [FRAME_BITS-1:0] cur_frame;

   assign accept = in_valid && in_ready;

   mtm_ser_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear ((state_q == StIdle) || (state_q == StFin)),
      .tick  (tick)
   );

   // Frame index 0 carries the most significant data byte.
   always_comb begin
      byte_sel = data_q[7:0];
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (frame_cnt_q == FW'(DATA_BYTES - 1 - i)) byte_sel = data_q[8*i +: 8];
      end
   end

   assign last_frame = (err_q != 3'b000) || (frame_cnt_q == FW'(DATA_BYTES));

   always_comb begin
      if (err_q != 3'b000) begin
         cur_frame = make_frame(TYPE_CTL, err_payload(err_q));
      end else if (frame_cnt_q == FW'(DATA_BYTES)) begin
         cur_frame = make_frame(TYPE_CTL, {1'b0, flags_q, crc_val});
      end else begin
         cur_frame = make_frame(TYPE_DATA, byte_sel);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = StLoad;
         StLoad:  state_d = StShift;
         StShift: begin
            if (tick && bit_cnt_q == 4'(FRAME_BITS - 1)) begin
               if (GAP_BITS > 0)    state_d = StGap;
               else if (last_frame) state_d = StFin;
               else                 state_d = StLoad;
            end
         end
         StGap:   if (tick && bit_cnt_q == 4'(GAP_BITS - 1)) state_d = last_frame ? StFin : StLoad;
         StFin:   state_d = in_valid ? StLoad : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sout     = 1'b1;
      busy     = 1'b0;
      in_ready = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle:  in_ready = 1'b1;
         StLoad:  begin sout = 1'b0;        busy = 1'b1; end
         StShift: begin sout = shreg_q[10]; busy = 1'b1; end
         StGap:   busy = 1'b1;
         StFin:   begin in_ready = 1'b1;    done = 1'b1; end
         default: ;
      endcase
   end

   // LOAD is the first cycle of the start bit; with CLK_DIV=1 it is the whole bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q      <= '0;
         flags_q     <= '0;
         err_q       <= '0;
         shreg_q     <= '1;
         bit_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         if (accept) begin
            data_q      <= data_in;
            flags_q     <= flags_in;
            err_q       <= err_in;
            frame_cnt_q <= '0;
         end
         unique case (state_q)
            StLoad: begin
               shreg_q   <= tick ? {cur_frame[9:0], 1'b1} : cur_frame;
               bit_cnt_q <= tick ? 4'd1 : 4'd0;
            end
            StShift: begin
               if (tick) begin
                  if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     if (state_d == StLoad) frame_cnt_q <= frame_cnt_q + FW'(1);
                  end else begin
                     shreg_q   <= {shreg_q[9:0], 1'b1};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end
            end
            StGap: begin
               if (tick) begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (state_d == StLoad) frame_cnt_q <= frame_cnt_q + FW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MTM_SER_CRC_GEN_EN
   // Two message bits per clock; a leading zero pads the odd-length message without
   // changing the CRC, and the run finishes well inside the first data frame.
   localparam int unsigned MW    = DW + 6;
   localparam int unsigned STEPS = MW / 2;
   localparam int unsigned SCW   = $clog2(STEPS + 1);

   logic [MW-1:0]  msg_q;
   logic [2:0]     crc_q;
   logic [SCW-1:0] crc_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         msg_q     <= '0;
         crc_q     <= '0;
         crc_cnt_q <= '0;
      end else if (accept) begin
         msg_q     <= {1'b0, data_in, 1'b0, flags_in};
         crc_q     <= '0;
         crc_cnt_q <= '0;
      end else if (crc_cnt_q != SCW'(STEPS)) begin
         crc_q     <= crc3_step(crc3_step(crc_q, msg_q[MW-1]), msg_q[MW-2]);
         msg_q     <= msg_q << 2;
         crc_cnt_q <= crc_cnt_q + SCW'(1);
      end
   end

   assign crc_val = crc_q;
`else
   logic [2:0] crc_q;

   always_ff @(posedge clk) begin
      if (rst)         crc_q <= '0;
      else if (accept) crc_q <= crc_in;
   end

   assign crc_val = crc_q;
`endif

endmodule
